// File: rtl/file_io_responder_if.sv
// rtl/file_io_responder_if.sv - AXI-light bus bundle carrying the result write-back
interface if_axi_light;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/file_io_responder.sv
// rtl/file_io_responder.sv - node file-op service over console byte FIFOs; FILE_IO_RESP_RESULT_WB_EN adds AXI result write-back
module file_io_responder #(
    parameter int          DEPTH       = 16,
    parameter logic [31:0] RESULT_ADDR = 32'h00FF_FF80
) (
    input  logic        clk,
    input  logic        res,
    input  logic        file_instr_valid,
    input  logic [31:0] file_instruction,
    input  logic [31:0] file_reg_a0,
    input  logic [31:0] file_reg_a1,
    input  logic [31:0] file_reg_a2,
    input  logic [31:0] axi_offset,
    input  logic        req_ack,
    output logic        sim_file_op_complete,
    output logic [31:0] result,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    if_axi_light.master m_axi
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [7:0] OP_PUTC = 8'h01;
    localparam logic [7:0] OP_GETC = 8'h02;
    localparam logic [7:0] OP_STAT = 8'h03;

    typedef enum logic [2:0] {
        IDLE, EXEC, DONE, DROP
`ifdef FILE_IO_RESP_RESULT_WB_EN
        , WR, RESP
`endif
    } state_t;

    state_t state, state_next;

    logic [7:0]  op_q;
    logic [7:0]  a0_q;
    logic [31:0] result_next;
    logic        getc_pop;
    logic        putc_push;

    logic [7:0]    in_mem [DEPTH];
    logic [PW-1:0] in_wr, in_rd;
    logic [CW-1:0] in_count;
    logic          in_full, in_empty, in_push;

    logic [7:0]    out_mem [DEPTH];
    logic [PW-1:0] out_wr, out_rd;
    logic [CW-1:0] out_count;
    logic          out_full, out_empty, out_pop;

    assign in_full   = (in_count == CW'(DEPTH));
    assign in_empty  = (in_count == '0);
    assign out_full  = (out_count == CW'(DEPTH));
    assign out_empty = (out_count == '0);

    assign in_ready  = !in_full;
    assign in_push   = in_valid && !in_full;
    assign out_valid = !out_empty;
    assign out_data  = out_mem[out_rd];
    assign out_pop   = out_ready && !out_empty;

    assign sim_file_op_complete = (state == DONE);

    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        result_next = result;
        getc_pop    = 1'b0;
        putc_push   = 1'b0;
        case (state)
            IDLE: if (file_instr_valid) state_next = EXEC;
            EXEC: begin
                case (op_q)
                    OP_PUTC: begin
                        if (out_full) begin
                            result_next = 32'hFFFF_FFFF;
                        end else begin
                            result_next = 32'h0;
                            putc_push   = 1'b1;
                        end
                    end
                    OP_GETC: begin
                        if (in_empty) begin
                            result_next = 32'hFFFF_FFFF;
                        end else begin
                            result_next = {24'h0, in_mem[in_rd]};
                            getc_pop    = 1'b1;
                        end
                    end
                    OP_STAT: result_next = {16'(in_count), 16'(out_count)};
                    default: result_next = 32'hFFFF_FFFE;
                endcase
`ifdef FILE_IO_RESP_RESULT_WB_EN
                state_next = WR;
`else
                state_next = DONE;
`endif
            end
`ifdef FILE_IO_RESP_RESULT_WB_EN
            // A channel whose valid has already dropped has completed its handshake.
            WR: if ((!m_axi.awvalid || m_axi.awready) && (!m_axi.wvalid || m_axi.wready))
                    state_next = RESP;
            RESP: if (m_axi.bvalid) state_next = DONE;
`endif
            DONE: if (req_ack) state_next = DROP;
            DROP: if (!file_instr_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            op_q   <= '0;
            a0_q   <= '0;
            result <= '0;
        end else begin
            if (state == IDLE && file_instr_valid) begin
                op_q <= file_instruction[7:0];
                a0_q <= file_reg_a0[7:0];
            end
            result <= result_next;
        end
    end

    always_ff @(posedge clk) begin
        if (in_push)   in_mem[in_wr]   <= in_data;
        if (putc_push) out_mem[out_wr] <= a0_q;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            in_wr     <= '0;
            in_rd     <= '0;
            in_count  <= '0;
            out_wr    <= '0;
            out_rd    <= '0;
            out_count <= '0;
        end else begin
            if (in_push)   in_wr  <= in_wr + PW'(1);
            if (getc_pop)  in_rd  <= in_rd + PW'(1);
            if (putc_push) out_wr <= out_wr + PW'(1);
            if (out_pop)   out_rd <= out_rd + PW'(1);
            if (in_push && !getc_pop)
                in_count <= in_count + CW'(1);
            else if (!in_push && getc_pop)
                in_count <= in_count - CW'(1);
            if (putc_push && !out_pop)
                out_count <= out_count + CW'(1);
            else if (!putc_push && out_pop)
                out_count <= out_count - CW'(1);
        end
    end

`ifdef FILE_IO_RESP_RESULT_WB_EN
    logic [31:0] offset_q;
    logic [31:0] aw_addr;
    logic [31:0] w_data;
    logic        aw_pending;
    logic        w_pending;

    always_ff @(posedge clk) begin
        if (res) begin
            offset_q <= '0;
        end else if (state == IDLE && file_instr_valid) begin
            offset_q <= axi_offset;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            aw_pending <= 1'b0;
            w_pending  <= 1'b0;
            aw_addr    <= '0;
            w_data     <= '0;
        end else if (state == EXEC) begin
            aw_pending <= 1'b1;
            w_pending  <= 1'b1;
            aw_addr    <= offset_q + RESULT_ADDR;
            w_data     <= result_next;
        end else begin
            if (aw_pending && m_axi.awready) aw_pending <= 1'b0;
            if (w_pending && m_axi.wready)   w_pending  <= 1'b0;
        end
    end

    assign m_axi.awaddr  = aw_addr;
    assign m_axi.awvalid = aw_pending;
    assign m_axi.wdata   = w_data;
    assign m_axi.wstrb   = w_pending ? 4'hF : 4'h0;
    assign m_axi.wvalid  = w_pending;
    assign m_axi.bready  = (state == RESP);
`else
    assign m_axi.awaddr  = '0;
    assign m_axi.awvalid = 1'b0;
    assign m_axi.wdata   = '0;
    assign m_axi.wstrb   = '0;
    assign m_axi.wvalid  = 1'b0;
    assign m_axi.bready  = 1'b1;
`endif
    assign m_axi.araddr  = '0;
    assign m_axi.arvalid = 1'b0;
    assign m_axi.rready  = 1'b1;

    logic unused_bits;
    assign unused_bits = ^{file_instruction[31:8], file_reg_a0[31:8], file_reg_a1, file_reg_a2,
                           m_axi.bresp, m_axi.arready, m_axi.rdata, m_axi.rresp, m_axi.rvalid
`ifndef FILE_IO_RESP_RESULT_WB_EN
                           , m_axi.awready, m_axi.wready, m_axi.bvalid, axi_offset, RESULT_ADDR
`endif
                          };
endmodule

// File: tb/tb_file_io_responder.sv
// tb/tb_file_io_responder.sv - directed bench for file_io_responder, both with and without FILE_IO_RESP_RESULT_WB_EN
module tb_file_io_responder;
`ifdef FILE_IO_RESP_RESULT_WB_EN
    localparam int LAT = 4;
    localparam logic [31:0] BREADY_IDLE = 32'd0;
`else
    localparam int LAT = 2;
    localparam logic [31:0] BREADY_IDLE = 32'd1;
`endif

    logic        clk = 1'b0;
    logic        res;
    logic        file_instr_valid;
    logic [31:0] file_instruction;
    logic [31:0] file_reg_a0, file_reg_a1, file_reg_a2;
    logic [31:0] axi_offset;
    logic        req_ack;
    logic        sim_file_op_complete;
    logic [31:0] result;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    if_axi_light axi();

    file_io_responder dut (
        .clk                  (clk),
        .res                  (res),
        .file_instr_valid     (file_instr_valid),
        .file_instruction     (file_instruction),
        .file_reg_a0          (file_reg_a0),
        .file_reg_a1          (file_reg_a1),
        .file_reg_a2          (file_reg_a2),
        .axi_offset           (axi_offset),
        .req_ack              (req_ack),
        .sim_file_op_complete (sim_file_op_complete),
        .result               (result),
        .in_valid             (in_valid),
        .in_data              (in_data),
        .in_ready             (in_ready),
        .out_valid            (out_valid),
        .out_data             (out_data),
        .out_ready            (out_ready),
        .m_axi                (axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          lat;
    int          aw_at;
    int          w_first;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [31:0] cap_wstrb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request; lat is the index of the first edge at which completion is sampled high.
    task automatic do_op(input logic [7:0] op, input logic [7:0] b, input int aw_delay, input int hold);
        int stall;
        stall     = 0;
        lat       = 0;
        aw_at     = 0;
        w_first   = 0;
        cap_addr  = '0;
        cap_wdata = '0;
        cap_wstrb = '0;
        if (aw_delay > 0) axi.awready = 1'b0;
        file_instruction = {24'h123456, op};
        file_reg_a0      = {24'hABCDEF, b};
        file_instr_valid = 1'b1;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (axi.awvalid && aw_at == 0) begin
                aw_at     = i;
                cap_addr  = axi.awaddr;
                cap_wdata = axi.wdata;
                cap_wstrb = {28'h0, axi.wstrb};
            end
            if (axi.awvalid && !axi.wvalid) w_first = 1;
            if (axi.awvalid && !axi.awready) begin
                stall++;
                if (stall > aw_delay) axi.awready = 1'b1;
            end
            if (sim_file_op_complete) lat = i;
        end
        axi.awready = 1'b1;
        req_ack = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("complete_drop", 32'(sim_file_op_complete), 32'd0);
        end
        file_instr_valid = 1'b0;
        req_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic host_push(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic host_pop();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        res = 1'b1;
        file_instr_valid = 1'b0;
        file_instruction = '0;
        file_reg_a0 = '0;
        file_reg_a1 = 32'h1111_1111;
        file_reg_a2 = 32'h2222_2222;
        axi_offset = '0;
        req_ack = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        axi.awready = 1'b1;
        axi.wready = 1'b1;
        axi.bvalid = 1'b1;
        axi.bresp = 2'b00;
        axi.arready = 1'b0;
        axi.rdata = '0;
        axi.rresp = 2'b00;
        axi.rvalid = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_complete", 32'(sim_file_op_complete), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_awvalid", 32'(axi.awvalid), 32'd0);
        check("rst_wvalid", 32'(axi.wvalid), 32'd0);
        check("rst_awaddr", axi.awaddr, 32'd0);
        check("rst_wdata", axi.wdata, 32'd0);
        check("rst_wstrb", 32'(axi.wstrb), 32'd0);
        check("rst_arvalid", 32'(axi.arvalid), 32'd0);
        check("rst_bready", 32'(axi.bready), BREADY_IDLE);
        res = 1'b0;
        @(negedge clk);

        do_op(8'h01, 8'h41, 0, 1);
        check("putc_lat", 32'(lat), 32'(LAT));
        check("putc_result", result, 32'd0);
`ifdef FILE_IO_RESP_RESULT_WB_EN
        check("putc_aw_at", 32'(aw_at), 32'd2);
        check("putc_awaddr", cap_addr, 32'h00FF_FF80);
        check("putc_wdata", cap_wdata, 32'd0);
        check("putc_wstrb", cap_wstrb, 32'hF);
`else
        check("putc_no_aw", 32'(aw_at), 32'd0);
`endif
        check("putc_out_valid", 32'(out_valid), 32'd1);
        check("putc_out_data", 32'(out_data), 32'h41);
        do_op(8'h03, 8'h00, 0, 1);
        check("stat_one_out", result, 32'h0000_0001);
        host_pop();
        check("pop_out_empty", 32'(out_valid), 32'd0);

        host_push(8'h55);
        do_op(8'h03, 8'h00, 0, 1);
        check("stat_one_in", result, 32'h0001_0000);
        do_op(8'h02, 8'h00, 0, 1);
        check("getc_byte", result, 32'h0000_0055);
        do_op(8'h02, 8'h00, 0, 1);
        check("getc_empty", result, 32'hFFFF_FFFF);
        do_op(8'h7F, 8'h33, 0, 1);
        check("bad_opcode", result, 32'hFFFF_FFFE);
        check("bad_no_push", 32'(out_valid), 32'd0);

        for (int i = 0; i < 17; i++) begin
            do_op(8'h01, 8'(8'h10 + i), 0, 1);
            check($sformatf("fill_%0d", i), result, (i == 16) ? 32'hFFFF_FFFF : 32'd0);
        end
        do_op(8'h03, 8'h00, 0, 1);
        check("stat_full", result, 32'h0000_0010);
        check("full_head", 32'(out_data), 32'h10);
        out_ready = 1'b1;
        repeat (16) @(negedge clk);
        out_ready = 1'b0;
        check("drain_empty", 32'(out_valid), 32'd0);

        axi_offset = 32'hFFFF_FFF0;
        do_op(8'h03, 8'h00, 3, 1);
        check("wrap_result", result, 32'd0);
`ifdef FILE_IO_RESP_RESULT_WB_EN
        check("wrap_lat", 32'(lat), 32'd7);
        check("wrap_awaddr", cap_addr, 32'h00FF_FF70);
        check("wrap_w_first", 32'(w_first), 32'd1);
`else
        check("wrap_lat", 32'(lat), 32'(LAT));
`endif
        axi_offset = '0;

        do_op(8'h01, 8'h99, 0, 3);
        do_op(8'h03, 8'h00, 0, 1);
        check("hold_one_push", result, 32'h0000_0001);
        check("hold_head", 32'(out_data), 32'h99);
        host_pop();

        host_push(8'h77);
        axi.bvalid = 1'b0;
        file_instruction = {24'h0, 8'h01};
        file_reg_a0 = 32'h22;
        file_instr_valid = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
`ifdef FILE_IO_RESP_RESULT_WB_EN
            if (axi.bready) lat = i;
`else
            if (sim_file_op_complete) lat = i;
`endif
        end
`ifdef FILE_IO_RESP_RESULT_WB_EN
        check("resp_reached", 32'(lat), 32'd3);
`else
        check("done_reached", 32'(lat), 32'd2);
`endif
        res = 1'b1;
        file_instr_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_complete", 32'(sim_file_op_complete), 32'd0);
        check("mid_rst_awvalid", 32'(axi.awvalid), 32'd0);
        check("mid_rst_wvalid", 32'(axi.wvalid), 32'd0);
        check("mid_rst_bready", 32'(axi.bready), BREADY_IDLE);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_result", result, 32'd0);
        res = 1'b0;
        axi.bvalid = 1'b1;
        @(negedge clk);
        do_op(8'h03, 8'h00, 0, 1);
        check("post_rst_lat", 32'(lat), 32'(LAT));
        check("post_rst_stat", result, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
